// File: rtl/nibble_addsub_seq.sv
// Nibble-serial add/subtract sequencer built around one 4-bit CLA.
// Define NIBBLE_ADDSUB_FLAGS_EN to build the z/n/v status flags.
module nibble_addsub_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

module nibble_addsub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE, RUN, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       sum;
  logic             c_out;
  logic             last;

  nibble_addsub_cla4 u_cla (
    .a_i (a_sr_q[3:0]),
    .b_i (b_sr_q[3:0]),
    .c_i (carry_q),
    .s_o (sum),
    .c_o (c_out)
  );

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {sum, res_q[WIDTH-1:4]};
        a_sr_d  = a_sr_q >> 4;
        b_sr_d  = b_sr_q >> 4;
        carry_d = c_out;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cout_d  = c_out;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cout   = cout_q;

`ifdef NIBBLE_ADDSUB_FLAGS_EN
  logic z_q, z_d, n_q, n_d, v_q, v_d;

  // Flags come from the last nibble's CLA inputs and sum.
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    v_d = v_q;
    if (state_q == RUN && last) begin
      z_d = ({sum, res_q[WIDTH-1:4]} == '0);
      n_d = sum[3];
      v_d = (a_sr_q[3] ~^ b_sr_q[3])
          & (sum[3] ^ a_sr_q[3]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
      v_q <= v_d;
    end
  end

  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_v = v_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif
endmodule
